// File: rtl/intersection_phase_scheduler_if.sv
// Signal bundle between the intersection phase scheduler and its environment:
// car sensors in, signal heads and phase status out.
interface intersection_phase_scheduler_if;
    logic [3:0] car_req;
    logic [7:0] sig;
    logic [1:0] active;
    logic       phase_done;

    modport master (output car_req, input sig, input active, input phase_done);
    modport slave  (input car_req, output sig, output active, output phase_done);
endinterface

// File: rtl/intersection_phase_scheduler.sv
// Round-robin phase scheduler for a 4-approach intersection: GREEN -> YELLOW ->
// ALLRED -> GREEN with min/max green, yellow and clearance timing in cycles.
module intersection_phase_scheduler #(
    parameter int MIN_GREEN = 8,
    parameter int MAX_GREEN = 32,
    parameter int Y2RDELAY  = 3,
    parameter int R2GDELAY  = 2
) (
    input  logic clock,
    input  logic clear,
    intersection_phase_scheduler_if.slave bus
);
    localparam int MAX_GY = (MAX_GREEN > Y2RDELAY) ? MAX_GREEN : Y2RDELAY;
    localparam int MAX_D  = (MAX_GY > R2GDELAY) ? MAX_GY : R2GDELAY;
    localparam int CNT_W  = $clog2(MAX_D + 1);

    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(Y2RDELAY - 1);
    localparam logic [CNT_W-1:0] R_LAST   = CNT_W'(R2GDELAY - 1);

    localparam logic [1:0] HEAD_RED    = 2'd0;
    localparam logic [1:0] HEAD_YELLOW = 2'd1;
    localparam logic [1:0] HEAD_GREEN  = 2'd2;

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       active, active_nxt;
    logic [1:0]       next_app, next_app_nxt;
    logic [7:0]       sig, sig_nxt;
    logic             phase_done, phase_done_nxt;
    logic             other_req, yield_now, found;
    logic [1:0]       scan_idx;

    function automatic logic [7:0] head_sig(input logic [1:0] idx, input logic [1:0] code);
        head_sig = {6'b0, code} << {idx, 1'b0};
    endfunction

    always_ff @(posedge clock) begin
        if (clear) begin
            state      <= ST_GREEN;
            cnt        <= '0;
            active     <= 2'd0;
            next_app   <= 2'd0;
            sig        <= head_sig(2'd0, HEAD_GREEN);
            phase_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            active     <= active_nxt;
            next_app   <= next_app_nxt;
            sig        <= sig_nxt;
            phase_done <= phase_done_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        active_nxt     = active;
        next_app_nxt   = next_app;
        sig_nxt        = sig;
        phase_done_nxt = 1'b0;
        found          = 1'b0;
        scan_idx       = active;

        // The serving approach's own sensor only extends its green, never competes.
        other_req = |(bus.car_req & ~(4'b0001 << active));
        yield_now = other_req &&
                    (((cnt >= MIN_LAST) && !bus.car_req[active]) || (cnt == MAX_LAST));

        case (state)
            ST_GREEN: begin
                if (yield_now) begin
                    state_nxt = ST_YELLOW;
                    cnt_nxt   = '0;
                    sig_nxt   = head_sig(active, HEAD_YELLOW);
                    for (int k = 1; k < 4; k++) begin
                        scan_idx = active + 2'(k);
                        if (!found && bus.car_req[scan_idx]) begin
                            next_app_nxt = scan_idx;
                            found        = 1'b1;
                        end
                    end
                end else if (cnt != MAX_LAST) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_YELLOW: begin
                if (cnt == Y_LAST) begin
                    state_nxt = ST_ALLRED;
                    cnt_nxt   = '0;
                    sig_nxt   = 8'h00;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_ALLRED: begin
                if (cnt == R_LAST) begin
                    state_nxt      = ST_GREEN;
                    cnt_nxt        = '0;
                    active_nxt     = next_app;
                    sig_nxt        = head_sig(next_app, HEAD_GREEN);
                    phase_done_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt  = ST_GREEN;
                cnt_nxt    = '0;
                active_nxt = 2'd0;
                sig_nxt    = head_sig(2'd0, HEAD_GREEN);
            end
        endcase
    end

    assign bus.sig        = sig;
    assign bus.active     = active;
    assign bus.phase_done = phase_done;

    logic unused_red;
    assign unused_red = |HEAD_RED;
endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed-vector bench for intersection_phase_scheduler: table of held-input
// segments with expected outputs, hand sequences, and a per-cycle head monitor.
module tb_intersection_phase_scheduler;
    logic clock;
    logic clear;
    int   n_tests;
    int   n_fail;

    intersection_phase_scheduler_if bus ();

    intersection_phase_scheduler #(
        .MIN_GREEN(8), .MAX_GREEN(32), .Y2RDELAY(3), .R2GDELAY(2)
    ) dut (
        .clock(clock),
        .clear(clear),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int         id;
        logic       clr;
        logic [3:0] req;
        int         n;
        logic [7:0] sig;
        logic [1:0] act;
        logic       pd;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int id, input logic clr, input logic [3:0] req, input int n,
                       input logic [7:0] s, input logic [1:0] a, input logic pd);
        vec_t v;
        v.id = id; v.clr = clr; v.req = req; v.n = n; v.sig = s; v.act = a; v.pd = pd;
        tbl.push_back(v);
    endtask

    // Drive inputs, advance n cycles, compare the registered outputs after each edge.
    task automatic hold(input int id, input logic clr, input logic [3:0] req, input int n,
                        input logic [7:0] s, input logic [1:0] a, input logic pd);
        for (int c = 0; c < n; c++) begin
            clear       = clr;
            bus.car_req = req;
            @(posedge clock);
            #1;
            n_tests++;
            if (bus.sig !== s) begin
                n_fail++;
                $display("FAIL t%0d_sig cyc%0d: got %h expected %h", id, c, bus.sig, s);
            end
            n_tests++;
            if (bus.active !== a) begin
                n_fail++;
                $display("FAIL t%0d_active cyc%0d: got %0d expected %0d", id, c, bus.active, a);
            end
            n_tests++;
            if (bus.phase_done !== pd) begin
                n_fail++;
                $display("FAIL t%0d_phase_done cyc%0d: got %b expected %b", id, c, bus.phase_done, pd);
            end
        end
    endtask

    // Head-level safety invariants, skipped on the cycle right after a clear.
    logic       mon_en;
    logic       prev_valid;
    logic       clr_seen;
    logic [7:0] prev_sig;

    always @(negedge clock) begin
        if (mon_en) begin
            logic bad;
            int   nonred;
            bad    = 1'b0;
            nonred = 0;
            for (int i = 0; i < 4; i++) begin
                if (bus.sig[2*i +: 2] != 2'd0) nonred++;
                if (bus.sig[2*i +: 2] == 2'd3) bad = 1'b1;
                if (prev_valid && !clr_seen) begin
                    if (prev_sig[2*i +: 2] == 2'd2 && bus.sig[2*i +: 2] == 2'd0) bad = 1'b1;
                    if (prev_sig[2*i +: 2] == 2'd0 && bus.sig[2*i +: 2] == 2'd1) bad = 1'b1;
                    for (int j = 0; j < 4; j++)
                        if (j != i && prev_sig[2*i +: 2] == 2'd2 && bus.sig[2*j +: 2] == 2'd2)
                            bad = 1'b1;
                end
            end
            if (nonred > 1) bad = 1'b1;
            n_tests++;
            if (bad) begin
                n_fail++;
                $display("FAIL invariant: sig %h after %h, expected legal head transition", bus.sig, prev_sig);
            end
            prev_sig   = bus.sig;
            prev_valid = 1'b1;
        end
        clr_seen = clear;
    end

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        mon_en      = 1'b0;
        prev_valid  = 1'b0;
        clr_seen    = 1'b1;
        prev_sig    = 8'h00;
        clear       = 1'b1;
        bus.car_req = 4'b0000;

        // 1: idle after reset
        add(1, 1'b1, 4'b0000,   5, 8'h02, 2'd0, 1'b0);
        add(1, 1'b0, 4'b0000, 100, 8'h02, 2'd0, 1'b0);
        // 2: single competing request, minimum green then change to 2
        add(2, 1'b1, 4'b0100,   1, 8'h02, 2'd0, 1'b0);
        add(2, 1'b0, 4'b0100,   7, 8'h02, 2'd0, 1'b0);
        add(2, 1'b0, 4'b0100,   3, 8'h01, 2'd0, 1'b0);
        add(2, 1'b0, 4'b0100,   2, 8'h00, 2'd0, 1'b0);
        add(2, 1'b0, 4'b0100,   1, 8'h20, 2'd2, 1'b1);
        add(2, 1'b0, 4'b0100,   5, 8'h20, 2'd2, 1'b0);
        // 3: own sensor held extends to MAX, then 1 yields back at MIN once its sensor drops
        add(3, 1'b1, 4'b0011,   1, 8'h02, 2'd0, 1'b0);
        add(3, 1'b0, 4'b0011,  31, 8'h02, 2'd0, 1'b0);
        add(3, 1'b0, 4'b0011,   3, 8'h01, 2'd0, 1'b0);
        add(3, 1'b0, 4'b0011,   2, 8'h00, 2'd0, 1'b0);
        add(3, 1'b0, 4'b0001,   1, 8'h08, 2'd1, 1'b1);
        add(3, 1'b0, 4'b0001,   7, 8'h08, 2'd1, 1'b0);
        add(3, 1'b0, 4'b0001,   3, 8'h04, 2'd1, 1'b0);
        add(3, 1'b0, 4'b0001,   2, 8'h00, 2'd1, 1'b0);
        add(3, 1'b0, 4'b0001,   1, 8'h02, 2'd0, 1'b1);
        // 4: all others requesting, 13-cycle rotation 0,1,2,3,0
        add(4, 1'b1, 4'b1110,   1, 8'h02, 2'd0, 1'b0);
        add(4, 1'b0, 4'b1110,   7, 8'h02, 2'd0, 1'b0);
        add(4, 1'b0, 4'b1110,   3, 8'h01, 2'd0, 1'b0);
        add(4, 1'b0, 4'b1110,   2, 8'h00, 2'd0, 1'b0);
        add(4, 1'b0, 4'b1101,   1, 8'h08, 2'd1, 1'b1);
        add(4, 1'b0, 4'b1101,   7, 8'h08, 2'd1, 1'b0);
        add(4, 1'b0, 4'b1101,   3, 8'h04, 2'd1, 1'b0);
        add(4, 1'b0, 4'b1101,   2, 8'h00, 2'd1, 1'b0);
        add(4, 1'b0, 4'b1011,   1, 8'h20, 2'd2, 1'b1);
        add(4, 1'b0, 4'b1011,   7, 8'h20, 2'd2, 1'b0);
        add(4, 1'b0, 4'b1011,   3, 8'h10, 2'd2, 1'b0);
        add(4, 1'b0, 4'b1011,   2, 8'h00, 2'd2, 1'b0);
        add(4, 1'b0, 4'b0111,   1, 8'h80, 2'd3, 1'b1);
        add(4, 1'b0, 4'b0111,   7, 8'h80, 2'd3, 1'b0);
        add(4, 1'b0, 4'b0111,   3, 8'h40, 2'd3, 1'b0);
        add(4, 1'b0, 4'b0111,   2, 8'h00, 2'd3, 1'b0);
        add(4, 1'b0, 4'b1110,   1, 8'h02, 2'd0, 1'b1);

        hold(0, 1'b1, 4'b0000, 1, 8'h02, 2'd0, 1'b0);
        mon_en = 1'b1;
        for (int v = 0; v < tbl.size(); v++)
            hold(tbl[v].id, tbl[v].clr, tbl[v].req, tbl[v].n, tbl[v].sig, tbl[v].act, tbl[v].pd);

        // 5: one-cycle request exactly on the yield cycle still completes the change
        hold(5, 1'b1, 4'b0000, 1, 8'h02, 2'd0, 1'b0);
        hold(5, 1'b0, 4'b0000, 7, 8'h02, 2'd0, 1'b0);
        hold(5, 1'b0, 4'b0010, 1, 8'h01, 2'd0, 1'b0);
        hold(5, 1'b0, 4'b0000, 2, 8'h01, 2'd0, 1'b0);
        hold(5, 1'b0, 4'b0000, 2, 8'h00, 2'd0, 1'b0);
        hold(5, 1'b0, 4'b0000, 1, 8'h08, 2'd1, 1'b1);
        hold(5, 1'b0, 4'b0000, 40, 8'h08, 2'd1, 1'b0);

        // 6: clear during yellow of a 0->2 change
        hold(6, 1'b1, 4'b0100, 1, 8'h02, 2'd0, 1'b0);
        hold(6, 1'b0, 4'b0100, 7, 8'h02, 2'd0, 1'b0);
        hold(6, 1'b0, 4'b0100, 1, 8'h01, 2'd0, 1'b0);
        hold(6, 1'b1, 4'b0000, 1, 8'h02, 2'd0, 1'b0);
        hold(6, 1'b0, 4'b0000, 30, 8'h02, 2'd0, 1'b0);

        // 7: clear during all-red; new arbitration picks approach 1
        hold(7, 1'b1, 4'b0100, 1, 8'h02, 2'd0, 1'b0);
        hold(7, 1'b0, 4'b0100, 7, 8'h02, 2'd0, 1'b0);
        hold(7, 1'b0, 4'b0100, 3, 8'h01, 2'd0, 1'b0);
        hold(7, 1'b0, 4'b0100, 1, 8'h00, 2'd0, 1'b0);
        hold(7, 1'b1, 4'b0010, 1, 8'h02, 2'd0, 1'b0);
        hold(7, 1'b0, 4'b0010, 7, 8'h02, 2'd0, 1'b0);
        hold(7, 1'b0, 4'b0010, 3, 8'h01, 2'd0, 1'b0);
        hold(7, 1'b0, 4'b0010, 2, 8'h00, 2'd0, 1'b0);
        hold(7, 1'b0, 4'b0010, 1, 8'h08, 2'd1, 1'b1);

        // 8: clear during approach-3 green returns straight to approach 0
        hold(8, 1'b0, 4'b1000, 7, 8'h08, 2'd1, 1'b0);
        hold(8, 1'b0, 4'b1000, 3, 8'h04, 2'd1, 1'b0);
        hold(8, 1'b0, 4'b1000, 2, 8'h00, 2'd1, 1'b0);
        hold(8, 1'b0, 4'b1000, 1, 8'h80, 2'd3, 1'b1);
        hold(8, 1'b0, 4'b1000, 3, 8'h80, 2'd3, 1'b0);
        hold(8, 1'b1, 4'b0000, 1, 8'h02, 2'd0, 1'b0);
        hold(8, 1'b0, 4'b0000, 5, 8'h02, 2'd0, 1'b0);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
